// File: rtl/dcm_pkg.sv
// Shared widths and apply-FSM encoding for the dcm programming front-end.
package dcm_pkg;

  localparam int PROG_W = 3;
  localparam logic [PROG_W-1:0] PROG_MAX = 3'd7;

  // 2'd3 is never entered; the FSM default arm sends it back to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } apply_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, stability counter, rising-edge press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      level_d <= level;
      // Any return to the accepted level restarts the stability window.
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_p1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/dcm_prog_ctrl.sv
// Operator front-end for dcm: debounced up/down edit a pending rate, apply commits it with one update strobe.
module dcm_prog_ctrl
  import dcm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter bit WRAP            = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_apply,
  output logic [PROG_W-1:0] sel,
  output logic [PROG_W-1:0] prog,
  output logic              update,
  output logic              dirty
);

  logic up_level, up_press;
  logic down_level, down_press;
  logic apply_level, apply_press;
  apply_state_t state, state_nxt;

  function automatic logic [PROG_W-1:0] step_sel(input logic [PROG_W-1:0] cur,
                                                  input logic inc, input logic dec);
    logic [PROG_W-1:0] res;
    res = cur;
    if (inc && !dec) begin
      res = (cur == PROG_MAX && !WRAP) ? cur : cur + PROG_W'(1);
    end else if (dec && !inc) begin
      res = (cur == '0 && !WRAP) ? cur : cur - PROG_W'(1);
    end
    return res;
  endfunction

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_up (
    .clk(clk), .rst(rst), .raw(btn_up), .level(up_level), .press(up_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_down (
    .clk(clk), .rst(rst), .raw(btn_down), .level(down_level), .press(down_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_apply (
    .clk(clk), .rst(rst), .raw(btn_apply), .level(apply_level), .press(apply_press)
  );

  // Held levels of the edit buttons carry no meaning here; only their press pulses do.
  logic unused_levels;
  assign unused_levels = up_level ^ down_level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    update    = 1'b0;
    case (state)
      IDLE:    if (apply_press) state_nxt = ISSUE;
      ISSUE: begin
        update    = 1'b1;
        state_nxt = HOLD;
      end
      HOLD:    if (!apply_level) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // prog captures the pre-edit sel when apply and up/down land on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel   <= '0;
      prog  <= '0;
      dirty <= 1'b0;
    end else begin
      sel   <= step_sel(sel, up_press, down_press);
      dirty <= (sel != prog);
      if (state == IDLE && apply_press) begin
        prog <= sel;
      end
    end
  end

endmodule

// File: tb/tb_dcm_prog_ctrl.sv
// Randomised scoreboard bench: a wrapping and a saturating instance share the same buttons.
module tb_dcm_prog_ctrl;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_apply = 1'b0;
  logic [2:0] sel_w, prog_w, sel_s, prog_s;
  logic       upd_w, dirty_w, upd_s, dirty_s;

  int errors = 0;
  int checks = 0;

  int m_sel_w = 0, m_prog_w = 0, m_sel_s = 0, m_prog_s = 0;
  int exp_w[$];
  int exp_s[$];

  always #5 clk = ~clk;

  dcm_prog_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(3), .WRAP(1'b1)) dut_w (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_apply(btn_apply),
    .sel(sel_w), .prog(prog_w), .update(upd_w), .dirty(dirty_w)
  );

  dcm_prog_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(3), .WRAP(1'b0)) dut_s (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_apply(btn_apply),
    .sel(sel_s), .prog(prog_s), .update(upd_s), .dirty(dirty_s)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference behaviour: a press moves the selection by one, wrapping mod 8 or clamping to 0..7.
  function automatic int m_step(input int s, input bit u, input bit d, input bit wrap);
    int r;
    r = s;
    if (u && !d) r = wrap ? (s + 1) % 8 : ((s < 7) ? s + 1 : 7);
    if (d && !u) r = wrap ? (s + 7) % 8 : ((s > 0) ? s - 1 : 0);
    return r;
  endfunction

  task automatic model_press(input bit u, input bit d, input bit a);
    if (a) begin
      exp_w.push_back(m_sel_w);
      exp_s.push_back(m_sel_s);
      m_prog_w = m_sel_w;
      m_prog_s = m_sel_s;
    end
    m_sel_w = m_step(m_sel_w, u, d, 1'b1);
    m_sel_s = m_step(m_sel_s, u, d, 1'b0);
  endtask

  // Update monitor: every strobe must match the oldest outstanding apply.
  always @(negedge clk) begin
    if (upd_w) begin
      checks++;
      if (exp_w.size() == 0) begin
        errors++;
        $display("FAIL upd_w_unexpected: got prog=%0d expected no update", prog_w);
      end else begin
        int e;
        e = exp_w.pop_front();
        if (int'(prog_w) != e) begin
          errors++;
          $display("FAIL upd_w_prog: got %0d expected %0d", prog_w, e);
        end
      end
    end
    if (upd_s) begin
      checks++;
      if (exp_s.size() == 0) begin
        errors++;
        $display("FAIL upd_s_unexpected: got prog=%0d expected no update", prog_s);
      end else begin
        int e;
        e = exp_s.pop_front();
        if (int'(prog_s) != e) begin
          errors++;
          $display("FAIL upd_s_prog: got %0d expected %0d", prog_s, e);
        end
      end
    end
  end

  task automatic settle_checks(input string tag);
    chk({tag, ".sel_w"}, int'(sel_w), m_sel_w);
    chk({tag, ".sel_s"}, int'(sel_s), m_sel_s);
    chk({tag, ".prog_w"}, int'(prog_w), m_prog_w);
    chk({tag, ".prog_s"}, int'(prog_s), m_prog_s);
    chk({tag, ".dirty_w"}, int'(dirty_w), int'(m_sel_w != m_prog_w));
    chk({tag, ".dirty_s"}, int'(dirty_s), int'(m_sel_s != m_prog_s));
    chk({tag, ".pending_w"}, exp_w.size(), 0);
    chk({tag, ".pending_s"}, exp_s.size(), 0);
  endtask

  task automatic do_press(input bit u, input bit d, input bit a, input int hold, input int gap);
    @(negedge clk);
    model_press(u, d, a);
    btn_up = u; btn_down = d; btn_apply = a;
    repeat (hold) @(negedge clk);
    btn_up = 1'b0; btn_down = 1'b0; btn_apply = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_glitch(input int len);
    @(negedge clk);
    btn_down = 1'b1;
    btn_apply = 1'b1;
    repeat (len) @(negedge clk);
    btn_down = 1'b0;
    btn_apply = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // Asserts rst part-way through a high clock phase and checks outputs before any edge.
  task automatic mid_cycle_reset(input string tag);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    m_sel_w = 0; m_prog_w = 0; m_sel_s = 0; m_prog_s = 0;
    exp_w.delete();
    exp_s.delete();
    chk({tag, ".sel_w"}, int'(sel_w), 0);
    chk({tag, ".prog_w"}, int'(prog_w), 0);
    chk({tag, ".upd_w"}, int'(upd_w), 0);
    chk({tag, ".dirty_w"}, int'(dirty_w), 0);
    chk({tag, ".sel_s"}, int'(sel_s), 0);
    chk({tag, ".prog_s"}, int'(prog_s), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns the number of rising edges after the raise at which cond first showed.
  task automatic measure_update(output int lat, output int dirty_at7, output int dirty_at8);
    lat = 0; dirty_at7 = -1; dirty_at8 = -1;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (upd_w && lat == 0) lat = i;
      if (i == 7) dirty_at7 = int'(dirty_w);
      if (i == 8) dirty_at8 = int'(dirty_w);
    end
  endtask

  initial begin
    int lat, d7, d8, sel_before;
    #1;
    chk("por.sel_w", int'(sel_w), 0);
    chk("por.upd_w", int'(upd_w), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Clean presses, then an apply with latency and dirty timing.
    for (int i = 0; i < 3; i++) do_press(1'b1, 1'b0, 1'b0, 10, 10);
    settle_checks("three_ups");
    chk("three_ups.dirty_w_is1", int'(dirty_w), 1);
    @(negedge clk);
    model_press(1'b0, 1'b0, 1'b1);
    btn_apply = 1'b1;
    measure_update(lat, d7, d8);
    btn_apply = 1'b0;
    chk("apply.latency", lat, 7);
    chk("apply.dirty_before", d7, 1);
    chk("apply.dirty_after", d8, 0);
    repeat (10) @(negedge clk);
    settle_checks("apply");

    // Bounce on up: twenty cycles of toggling, then stable high.
    sel_before = int'(sel_w);
    for (int i = 0; i < 10; i++) begin
      btn_up = ~btn_up;
      repeat (2) @(negedge clk);
    end
    chk("bounce.no_change", int'(sel_w), sel_before);
    btn_up = 1'b1;
    model_press(1'b1, 1'b0, 1'b0);
    lat = 0;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (int'(sel_w) != sel_before && lat == 0) lat = i;
    end
    chk("bounce.latency", lat, 7);
    btn_up = 1'b0;
    repeat (10) @(negedge clk);
    settle_checks("bounce");

    // Glitches shorter than the debounce window.
    for (int g = 1; g < D; g++) do_glitch(g);
    settle_checks("glitch");

    // Simultaneous edits, then apply+up from sel=2.
    do_press(1'b1, 1'b1, 1'b0, 9, 10);
    settle_checks("up_down");
    while (m_sel_w != 2) do_press(1'b0, 1'b1, 1'b0, 8, 9);
    do_press(1'b1, 1'b0, 1'b1, 9, 10);
    settle_checks("apply_up");
    chk("apply_up.prog_w_is2", int'(prog_w), 2);

    // Wrap and saturate at the top, then at the bottom after a reset.
    while (m_sel_w != 7) do_press(1'b1, 1'b0, 1'b0, 8, 9);
    do_press(1'b1, 1'b0, 1'b0, 8, 9);
    settle_checks("top_edge");
    mid_cycle_reset("rst_mid");
    repeat (3) @(negedge clk);
    do_press(1'b0, 1'b1, 1'b0, 8, 9);
    settle_checks("bottom_edge");

    // Long apply hold gives one update; a second press gives another.
    do_press(1'b0, 1'b0, 1'b1, 50, 10);
    settle_checks("held_apply");
    do_press(1'b0, 1'b1, 1'b1, 10, 10);
    settle_checks("second_apply");

    // Reset while holding apply, then re-debounce the still-held button.
    @(negedge clk);
    model_press(1'b0, 1'b0, 1'b1);
    btn_apply = 1'b1;
    repeat (15) @(negedge clk);
    chk("hold.pending_w", exp_w.size(), 0);
    mid_cycle_reset("rst_hold");
    model_press(1'b0, 1'b0, 1'b1);
    measure_update(lat, d7, d8);
    chk("rst_hold.relatency", lat, 7);
    btn_apply = 1'b0;
    repeat (10) @(negedge clk);
    settle_checks("rst_hold");

    // Randomised traffic.
    for (int n = 0; n < 40; n++) begin
      int op, hold, gap;
      op   = $urandom_range(0, 5);
      hold = $urandom_range(D + 3, 12);
      gap  = $urandom_range(D + 4, 12);
      case (op)
        0: do_press(1'b1, 1'b0, 1'b0, hold, gap);
        1: do_press(1'b0, 1'b1, 1'b0, hold, gap);
        2: do_press(1'b0, 1'b0, 1'b1, hold, gap);
        3: do_press(1'b1, 1'b1, 1'b0, hold, gap);
        4: do_press(1'b1, 1'b0, 1'b1, hold, gap);
        default: do_glitch($urandom_range(1, D - 1));
      endcase
      settle_checks($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
